// File: rtl/tt_mux_pkg.sv
// Shared constants for the tile-mux project-select sequencer.
// Optional feature macro used by this slice: TT_MUX_ALL_OFF_EN.
package tt_mux_pkg;

  // Controller states. These are plain constants rather than an enum so that
  // netlists and older tools see them as 2-bit values.
  localparam logic [1:0] ST_IDLE = 2'd0;  // no slot selected
  localparam logic [1:0] ST_DIS  = 2'd1;  // all enables low, switching gap
  localparam logic [1:0] ST_RST  = 2'd2;  // new slot enabled, held in reset
  localparam logic [1:0] ST_RUN  = 2'd3;  // new slot enabled and released

  // Default per-slot output word width: {uio_oe, uio_out, uo_out}.
  localparam int OW_W_DEF = 24;

  // Default select width, and the "all off" command at that width.
  localparam int SEL_W_DEF = 5;
  localparam logic [SEL_W_DEF-1:0] ALL_OFF_ADDR = '1;

  // Width of the shared DIS/RST down-counter: it must hold max(gap, hold).
  function automatic int cnt_width(input int gap, input int hold);
    int m;
    m = (gap > hold) ? gap : hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tt_mux_if.sv
// Select-request bus between a requester and the tile-mux controller.
// Handshake: a request transfers on a rising clk edge where sel_valid and
// sel_ready are both high. The requester holds sel_valid and sel_addr stable
// until that edge. sel_err is a one-cycle response pulse, high in the cycle
// after an accepted request whose address was out of range.
interface tt_mux_if #(
  parameter int SEL_W = 5
);
  logic             sel_valid;
  logic             sel_ready;
  logic [SEL_W-1:0] sel_addr;
  logic             sel_err;

  modport master (output sel_valid, output sel_addr, input sel_ready, input sel_err);
  modport slave  (input sel_valid, input sel_addr, output sel_ready, output sel_err);
endinterface

// File: rtl/tt_mux_ow_select.sv
// N_PROJ:1 word multiplexer with a zero gate. Returns slot sel's word when en
// is high, otherwise zero. Indices at or above N_PROJ return zero.
module tt_mux_ow_select #(
  parameter int N_PROJ = 32,
  parameter int SEL_W  = 5,
  parameter int OW_W   = 24
) (
  input  logic [N_PROJ*OW_W-1:0] bus,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   en,
  output logic [OW_W-1:0]        word
);

  // OR of all slices, each gated by its own address match.
  always_comb begin
    word = '0;
    for (int i = 0; i < N_PROJ; i++) begin
      if (en && (sel == SEL_W'(i))) begin
        word = word | bus[i*OW_W +: OW_W];
      end
    end
  end

endmodule

// File: rtl/tt_mux_ctrl.sv
// Project-select sequencer for the tile mux. Switches between user-project
// slots with a safe sequence: all enables low for GAP cycles, then the new
// slot enabled with its reset held for RST_HOLD cycles, then released.
// Optional feature macro: TT_MUX_ALL_OFF_EN (all-ones address = "all off").
module tt_mux_ctrl
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ   = 32,
  parameter int SEL_W    = 5,
  parameter int OW_W     = OW_W_DEF,
  parameter int GAP      = 2,
  parameter int RST_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  tt_mux_if.slave                sel,
  output logic [N_PROJ-1:0]      ena_o,
  output logic                   proj_rst_n,
  output logic [SEL_W-1:0]       cur_addr,
  output logic                   active,
  input  logic [N_PROJ*OW_W-1:0] ow_bus,
  output logic [OW_W-1:0]        ow_out,
  output logic [1:0]             dbg_state
);

  localparam int CNT_W = cnt_width(GAP, RST_HOLD);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(RST_HOLD - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             sel_err_q;
  logic             accept;
  logic             addr_bad;
  logic             slot_on;

`ifdef TT_MUX_ALL_OFF_EN
  localparam logic [SEL_W-1:0] ALL_OFF = '1;
  logic off_pending;  // current DIS phase ends in IDLE instead of RST
  logic is_all_off;
  assign is_all_off = (sel.sel_addr == ALL_OFF);
`endif

  // Requests are only taken while no switch sequence is in flight.
  assign sel.sel_ready = (state == ST_IDLE) || (state == ST_RUN);
  assign accept        = sel.sel_valid && sel.sel_ready;
  assign addr_bad      = (32'(sel.sel_addr) >= 32'(N_PROJ));
  assign sel.sel_err   = sel_err_q;

  assign slot_on    = (state == ST_RST) || (state == ST_RUN);
  assign proj_rst_n = (state == ST_RUN);
  assign active     = (state == ST_RUN);
  assign dbg_state  = state;

  // Sequencer: accept requests, walk DIS -> RST -> RUN with the shared counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur_addr  <= '0;
      sel_err_q <= 1'b0;
`ifdef TT_MUX_ALL_OFF_EN
      off_pending <= 1'b0;
`endif
    end else begin
      sel_err_q <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN: begin
          if (accept) begin
`ifdef TT_MUX_ALL_OFF_EN
            if (is_all_off) begin
              state       <= ST_DIS;
              cnt         <= GAP_LOAD;
              cur_addr    <= '0;
              off_pending <= 1'b1;
            end else
`endif
            if (addr_bad) begin
              sel_err_q <= 1'b1;
            end else begin
              state    <= ST_DIS;
              cnt      <= GAP_LOAD;
              cur_addr <= sel.sel_addr;
`ifdef TT_MUX_ALL_OFF_EN
              off_pending <= 1'b0;
`endif
            end
          end
        end
        ST_DIS: begin
          if (cnt == '0) begin
`ifdef TT_MUX_ALL_OFF_EN
            if (off_pending) begin
              state       <= ST_IDLE;
              off_pending <= 1'b0;
            end else begin
              state <= ST_RST;
              cnt   <= HOLD_LOAD;
            end
`else
            state <= ST_RST;
            cnt   <= HOLD_LOAD;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RST: begin
          if (cnt == '0) begin
            state <= ST_RUN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // One-hot enable decode; all zero outside RST/RUN, so never multi-hot.
  always_comb begin
    ena_o = '0;
    for (int i = 0; i < N_PROJ; i++) begin
      ena_o[i] = slot_on && (cur_addr == SEL_W'(i));
    end
  end

  tt_mux_ow_select #(
    .N_PROJ (N_PROJ),
    .SEL_W  (SEL_W),
    .OW_W   (OW_W)
  ) u_ow_select (
    .bus  (ow_bus),
    .sel  (cur_addr),
    .en   (slot_on),
    .word (ow_out)
  );

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Bench for tt_mux_ctrl: 32 slots, 6-bit select (so address 40 is out of
// range), GAP=2, RST_HOLD=4. Optional section under TT_MUX_ALL_OFF_EN.
module tb_tt_mux_ctrl;

  localparam int N_PROJ   = 32;
  localparam int SEL_W    = 6;
  localparam int OW_W     = 24;
  localparam int GAP      = 2;
  localparam int RST_HOLD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_mux_if #(.SEL_W(SEL_W)) sel_bus ();

  logic [N_PROJ-1:0]      ena_o;
  logic                   proj_rst_n;
  logic [SEL_W-1:0]       cur_addr;
  logic                   active;
  logic [N_PROJ*OW_W-1:0] ow_bus;
  logic [OW_W-1:0]        ow_out;
  logic [1:0]             dbg_state;

  tt_mux_ctrl #(
    .N_PROJ   (N_PROJ),
    .SEL_W    (SEL_W),
    .OW_W     (OW_W),
    .GAP      (GAP),
    .RST_HOLD (RST_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel        (sel_bus.slave),
    .ena_o      (ena_o),
    .proj_rst_n (proj_rst_n),
    .cur_addr   (cur_addr),
    .active     (active),
    .ow_bus     (ow_bus),
    .ow_out     (ow_out),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic mon_en = 1'b0;

  function automatic logic [OW_W-1:0] ow_word(input int i);
    logic [7:0] a;
    a = i[7:0];
    return {a, 8'hC3, a + 8'h40};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [SEL_W-1:0] a);
    rst = r;
    sel_bus.sel_valid = v;
    sel_bus.sel_addr  = a;
  endtask

  // Enables must never be multi-hot in any cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      total++;
      if ($countones(ena_o) > 1) begin
        bad++;
        $display("FAIL ena_onehot: got %0h expected at most one bit", ena_o);
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic             rst;
    logic             valid;
    logic [SEL_W-1:0] addr;
    logic             exp_on;   // slot enabled (RST or RUN)
    logic             exp_run;  // RUN: proj_rst_n and active high
    logic             exp_rdy;
    logic             exp_err;
    logic [SEL_W-1:0] exp_cur;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input int a, input logic on,
                              input logic run, input logic rdy, input logic err, input int cur);
    vec_t x;
    x.rst = r; x.valid = v; x.addr = SEL_W'(a);
    x.exp_on = on; x.exp_run = run; x.exp_rdy = rdy; x.exp_err = err; x.exp_cur = SEL_W'(cur);
    return x;
  endfunction

  task automatic check_outputs(input string tag, input logic on, input logic run,
                               input logic rdy, input logic err, input logic [SEL_W-1:0] cur);
    logic [N_PROJ-1:0] e_ena;
    logic [OW_W-1:0]   e_ow;
    e_ena = on ? (N_PROJ'(1) << cur) : '0;
    e_ow  = on ? ow_word(int'(cur)) : '0;
    chk({tag, "_ena"},    64'(ena_o),         64'(e_ena));
    chk({tag, "_rstn"},   64'(proj_rst_n),    64'(run));
    chk({tag, "_active"}, 64'(active),        64'(run));
    chk({tag, "_ready"},  64'(sel_bus.sel_ready), 64'(rdy));
    chk({tag, "_err"},    64'(sel_bus.sel_err),   64'(err));
    chk({tag, "_cur"},    64'(cur_addr),      64'(cur));
    chk({tag, "_ow"},     64'(ow_out),        64'(e_ow));
  endtask

  initial begin
    int rise_ena;
    int rise_act;
    int idx;

    for (int i = 0; i < N_PROJ; i++) ow_bus[i*OW_W +: OW_W] = ow_word(i);
    drive(1'b1, 1'b0, '0);

    //           rst valid addr  on run rdy err cur
    // reset held 3 cycles
    vecs.push_back(mk(1, 0, 0,    0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 7,    0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0,    0, 0, 1, 0, 0));
    // select 22: DIS x2 (request in DIS ignored), RST x4 (request ignored), RUN
    vecs.push_back(mk(0, 1, 22,   0, 0, 0, 0, 22));
    vecs.push_back(mk(0, 1, 9,    0, 0, 0, 0, 22));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 22));
    vecs.push_back(mk(0, 1, 3,    1, 0, 0, 0, 22));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 22));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 22));
    vecs.push_back(mk(0, 0, 0,    1, 1, 1, 0, 22));
    vecs.push_back(mk(0, 0, 0,    1, 1, 1, 0, 22));
    // switch 22 -> 5
    vecs.push_back(mk(0, 1, 5,    0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 1, 1, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 1, 1, 0, 5));
    // out-of-range 40: one-cycle error, nothing else moves
    vecs.push_back(mk(0, 1, 40,   1, 1, 1, 1, 5));
    vecs.push_back(mk(0, 0, 0,    1, 1, 1, 0, 5));
    // reselect 5: forced project reset for 6 cycles
    vecs.push_back(mk(0, 1, 5,    0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 0, 0, 0, 5));
    vecs.push_back(mk(0, 0, 0,    1, 1, 1, 0, 5));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].addr);
      step();
      if (i == 0) mon_en = 1'b1;
      check_outputs($sformatf("v%0d", i), vecs[i].exp_on, vecs[i].exp_run,
                    vecs[i].exp_rdy, vecs[i].exp_err, vecs[i].exp_cur);
    end

    // ---- reset pulsed during RST of slot 9 ----
    drive(1'b0, 1'b1, SEL_W'(9));
    step();
    drive(1'b0, 1'b0, '0);
    step();
    step();
    check_outputs("rst9_inrst", 1'b1, 1'b0, 1'b0, 1'b0, SEL_W'(9));
    drive(1'b1, 1'b0, '0);
    step();
    check_outputs("rst9_idle", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("rst9_state", 64'(dbg_state), 64'(tt_mux_pkg::ST_IDLE));

    // ---- out-of-range request from IDLE ----
    drive(1'b0, 1'b1, SEL_W'(40));
    step();
    check_outputs("idle_oor", 1'b0, 1'b0, 1'b1, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    step();
    check_outputs("idle_oor_after", 1'b0, 1'b0, 1'b1, 1'b0, '0);

    // ---- select 9 again: measure latency from the accept edge ----
    drive(1'b0, 1'b1, SEL_W'(9));
    step();
    drive(1'b0, 1'b0, '0);
    idx = 1;
    rise_ena = -1;
    rise_act = -1;
    while ((idx <= 20) && (rise_act < 0)) begin
      if ((ena_o != '0) && (rise_ena < 0)) rise_ena = idx;
      if (active) rise_act = idx;
      if (rise_act < 0) begin
        step();
        idx++;
      end
    end
    chk("lat_ena_rise",    64'(rise_ena), 64'(GAP + 1));
    chk("lat_active_rise", 64'(rise_act), 64'(GAP + RST_HOLD + 1));
    check_outputs("lat_run", 1'b1, 1'b1, 1'b1, 1'b0, SEL_W'(9));

    // ---- ow_out follows the selected slice combinationally ----
    ow_bus[9*OW_W +: OW_W] = 24'h123456;
    ow_bus[8*OW_W +: OW_W] = 24'hFFFFFF;
    #1;
    chk("ow_comb", 64'(ow_out), 64'(24'h123456));
    ow_bus[9*OW_W +: OW_W] = ow_word(9);
    ow_bus[8*OW_W +: OW_W] = ow_word(8);
    #1;

`ifdef TT_MUX_ALL_OFF_EN
    // ---- all-off command: DIS for GAP cycles, then IDLE ----
    drive(1'b0, 1'b1, '1);
    step();
    drive(1'b0, 1'b0, '0);
    check_outputs("off_dis0", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    check_outputs("off_dis1", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    check_outputs("off_idle", 1'b0, 1'b0, 1'b1, 1'b0, '0);
    chk("off_state", 64'(dbg_state), 64'(tt_mux_pkg::ST_IDLE));
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
